// File: rtl/atm_pkg.sv
// Shared types and width helpers for the multi-account ATM controller.
package atm_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AUTH = 3'd1,
        S_MENU = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_INQ   = 3'd0,
        OP_WDR   = 3'd1,
        OP_DEP   = 3'd2,
        OP_CHPIN = 3'd3,
        OP_EXIT  = 3'd4
    } op_t;

    typedef enum logic [2:0] {
        E_NONE       = 3'd0,
        E_BAD_ACC    = 3'd1,
        E_WRONG_PIN  = 3'd2,
        E_LOCKED     = 3'd3,
        E_INSUFF     = 3'd4,
        E_OVERFLOW   = 3'd5,
        E_TIMEOUT    = 3'd6,
        E_ILLEGAL_OP = 3'd7
    } err_t;

    // Bits needed to hold values 0..max inclusive (at least 1).
    function automatic int unsigned cnt_w(int unsigned max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

    // Sized so that the first out-of-range index (NUM_ACC) can be presented and rejected.
    function automatic int unsigned acc_w(int unsigned num_acc);
        return cnt_w(num_acc);
    endfunction

endpackage

// File: rtl/atm_acct_rf.sv
// Per-account register file: balance, PIN, lock bit and fail counter.
module atm_acct_rf #(
    parameter int unsigned NUM_ACC  = 16,
    parameter int unsigned ACC_W    = 5,
    parameter int unsigned BAL_W    = 16,
    parameter int unsigned PIN_W    = 16,
    parameter int unsigned FAIL_W   = 2,
    parameter int unsigned INIT_BAL = 500,
    parameter int unsigned INIT_PIN = 16'h1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ACC_W-1:0]  rd_idx,
    output logic [BAL_W-1:0]  rd_bal,
    output logic [PIN_W-1:0]  rd_pin,
    output logic              rd_lock,
    output logic [FAIL_W-1:0] rd_fail,
    input  logic              we,
    input  logic [ACC_W-1:0]  wr_idx,
    input  logic [BAL_W-1:0]  wr_bal,
    input  logic [PIN_W-1:0]  wr_pin,
    input  logic              wr_lock,
    input  logic [FAIL_W-1:0] wr_fail
);

    localparam int unsigned IDX_W = $clog2(NUM_ACC);

    logic [BAL_W-1:0]  bal_mem  [NUM_ACC];
    logic [PIN_W-1:0]  pin_mem  [NUM_ACC];
    logic              lock_mem [NUM_ACC];
    logic [FAIL_W-1:0] fail_mem [NUM_ACC];

    logic rd_ok;
    logic wr_ok;

    assign rd_ok = (rd_idx < ACC_W'(NUM_ACC));
    assign wr_ok = (wr_idx < ACC_W'(NUM_ACC));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_ACC; k++) begin
                bal_mem[k]  <= BAL_W'(INIT_BAL);
                pin_mem[k]  <= PIN_W'(INIT_PIN + k);
                lock_mem[k] <= 1'b0;
                fail_mem[k] <= '0;
            end
        end else if (we && wr_ok) begin
            bal_mem[wr_idx[IDX_W-1:0]]  <= wr_bal;
            pin_mem[wr_idx[IDX_W-1:0]]  <= wr_pin;
            lock_mem[wr_idx[IDX_W-1:0]] <= wr_lock;
            fail_mem[wr_idx[IDX_W-1:0]] <= wr_fail;
        end
    end

    always_comb begin
        rd_bal  = '0;
        rd_pin  = '0;
        rd_lock = 1'b0;
        rd_fail = '0;
        if (rd_ok) begin
            rd_bal  = bal_mem[rd_idx[IDX_W-1:0]];
            rd_pin  = pin_mem[rd_idx[IDX_W-1:0]];
            rd_lock = lock_mem[rd_idx[IDX_W-1:0]];
            rd_fail = fail_mem[rd_idx[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/atm_ctrl_param.sv
// Multi-account ATM session controller: login with lockout, transactions, idle timeout.
module atm_ctrl_param
    import atm_pkg::*;
#(
    parameter int unsigned NUM_ACC     = 16,
    parameter int unsigned BAL_W       = 16,
    parameter int unsigned PIN_W       = 16,
    parameter int unsigned INIT_BAL    = 500,
    parameter int unsigned INIT_PIN    = 16'h1000,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned ACC_W      = acc_w(NUM_ACC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic [ACC_W-1:0]  acc_num,
    input  logic [PIN_W-1:0]  pin,
    input  logic [2:0]        operation,
    input  logic [BAL_W-1:0]  amount,
    input  logic [PIN_W-1:0]  new_pin,
    input  logic              language,
    output logic [BAL_W-1:0]  balance,
    output logic [2:0]        current_state,
    output logic              done,
    output logic [2:0]        error_code,
    output logic              locked,
    output logic              lang_sel
);

    localparam int unsigned FAIL_W = cnt_w(MAX_TRIES);
    localparam int unsigned TMR_W  = cnt_w(TIMEOUT_CYC);

    state_t            state_q, state_d;
    err_t              err_q, err_d;
    op_t               op_q, op_d;
    logic              locked_q, locked_d;
    logic              lang_q, lang_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [BAL_W-1:0]  amt_q, amt_d;
    logic [PIN_W-1:0]  npin_q, npin_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic [ACC_W-1:0]  rd_idx;
    logic [BAL_W-1:0]  rd_bal, wr_bal;
    logic [PIN_W-1:0]  rd_pin, wr_pin;
    logic              rd_lock, wr_lock, we;
    logic [FAIL_W-1:0] rd_fail, wr_fail, fail_inc;
    logic [BAL_W:0]    sum;
    logic              expire;

    atm_acct_rf #(
        .NUM_ACC  (NUM_ACC),
        .ACC_W    (ACC_W),
        .BAL_W    (BAL_W),
        .PIN_W    (PIN_W),
        .FAIL_W   (FAIL_W),
        .INIT_BAL (INIT_BAL),
        .INIT_PIN (INIT_PIN)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (rd_idx),
        .rd_bal  (rd_bal),
        .rd_pin  (rd_pin),
        .rd_lock (rd_lock),
        .rd_fail (rd_fail),
        .we      (we),
        .wr_idx  (acc_q),
        .wr_bal  (wr_bal),
        .wr_pin  (wr_pin),
        .wr_lock (wr_lock),
        .wr_fail (wr_fail)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            err_q    <= E_NONE;
            op_q     <= OP_INQ;
            locked_q <= 1'b0;
            lang_q   <= 1'b0;
            acc_q    <= '0;
            amt_q    <= '0;
            npin_q   <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            op_q     <= op_d;
            locked_q <= locked_d;
            lang_q   <= lang_d;
            acc_q    <= acc_d;
            amt_q    <= amt_d;
            npin_q   <= npin_d;
            timer_q  <= timer_d;
        end
    end

    // The single read port looks at the requested account in IDLE, the session account otherwise.
    assign rd_idx   = (state_q == S_IDLE) ? acc_num : acc_q;
    assign sum      = {1'b0, rd_bal} + {1'b0, amt_q};
    assign fail_inc = rd_fail + 1'b1;
    assign expire   = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        op_d     = op_q;
        locked_d = locked_q;
        lang_d   = lang_q;
        acc_d    = acc_q;
        amt_d    = amt_q;
        npin_d   = npin_q;
        timer_d  = '0;
        we       = 1'b0;
        wr_bal   = rd_bal;
        wr_pin   = rd_pin;
        wr_lock  = rd_lock;
        wr_fail  = rd_fail;
        case (state_q)
            S_IDLE: if (valid) begin
                if (acc_num >= ACC_W'(NUM_ACC)) begin
                    err_d    = E_BAD_ACC;
                    locked_d = 1'b0;
                end else if (rd_lock) begin
                    err_d    = E_LOCKED;
                    locked_d = 1'b1;
                end else begin
                    acc_d    = acc_num;
                    lang_d   = language;
                    err_d    = E_NONE;
                    locked_d = 1'b0;
                    state_d  = S_AUTH;
                end
            end
            S_AUTH: if (valid) begin
                we = 1'b1;
                if (pin == rd_pin) begin
                    wr_fail = '0;
                    err_d   = E_NONE;
                    state_d = S_MENU;
                end else begin
                    wr_fail = fail_inc;
                    err_d   = E_WRONG_PIN;
                    if (fail_inc == FAIL_W'(MAX_TRIES)) begin
                        wr_lock  = 1'b1;
                        locked_d = 1'b1;
                        err_d    = E_LOCKED;
                        state_d  = S_IDLE;
                    end
                end
            end else if (expire) begin
                err_d   = E_TIMEOUT;
                state_d = S_IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            S_MENU: if (valid) begin
                if (operation > OP_EXIT) begin
                    err_d = E_ILLEGAL_OP;
                end else begin
                    op_d    = op_t'(operation);
                    amt_d   = amount;
                    npin_d  = new_pin;
                    err_d   = E_NONE;
                    state_d = S_EXEC;
                end
            end else if (expire) begin
                err_d   = E_TIMEOUT;
                state_d = S_IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            S_EXEC: begin
                case (op_q)
                    OP_WDR: begin
                        if (amt_q > rd_bal) err_d = E_INSUFF;
                        else begin
                            we     = 1'b1;
                            wr_bal = rd_bal - amt_q;
                        end
                    end
                    OP_DEP: begin
                        if (sum[BAL_W]) err_d = E_OVERFLOW;
                        else begin
                            we     = 1'b1;
                            wr_bal = sum[BAL_W-1:0];
                        end
                    end
                    OP_CHPIN: begin
                        we     = 1'b1;
                        wr_pin = npin_q;
                    end
                    default: ;
                endcase
                state_d = S_DONE;
            end
            S_DONE:  state_d = (op_q == OP_EXIT) ? S_IDLE : S_MENU;
            default: state_d = S_IDLE;
        endcase
    end

    assign balance       = (state_q == S_IDLE) ? '0 : rd_bal;
    assign current_state = state_q;
    assign done          = (state_q == S_DONE);
    assign error_code    = err_q;
    assign locked        = locked_q;
    assign lang_sel      = lang_q;

endmodule

// File: tb/tb_atm_ctrl_param.sv
// Directed bench for atm_ctrl_param with NUM_ACC=16, 16-bit balances and PINs.
module tb_atm_ctrl_param;
    import atm_pkg::*;

    localparam int unsigned AW = acc_w(16);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [AW-1:0] acc_num = '0;
    logic [15:0]   pin = '0;
    logic [2:0]    operation = '0;
    logic [15:0]   amount = '0;
    logic [15:0]   new_pin = '0;
    logic          language = 1'b0;
    logic [15:0]   balance;
    logic [2:0]    current_state;
    logic          done;
    logic [2:0]    error_code;
    logic          locked;
    logic          lang_sel;

    int n_vec = 0;
    int n_err = 0;

    atm_ctrl_param #(
        .NUM_ACC     (16),
        .BAL_W       (16),
        .PIN_W       (16),
        .INIT_BAL    (500),
        .INIT_PIN    (16'h1000),
        .MAX_TRIES   (3),
        .TIMEOUT_CYC (1024)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid         (valid),
        .acc_num       (acc_num),
        .pin           (pin),
        .operation     (operation),
        .amount        (amount),
        .new_pin       (new_pin),
        .language      (language),
        .balance       (balance),
        .current_state (current_state),
        .done          (done),
        .error_code    (error_code),
        .locked        (locked),
        .lang_sel      (lang_sel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic login(input int acc, input logic [15:0] p);
        valid   = 1'b1;
        acc_num = AW'(acc);
        step();
        check("auth_state", 32'(current_state), 1);
        pin = p;
        step();
        valid = 1'b0;
        check("menu_state", 32'(current_state), 2);
    endtask

    task automatic op_to_done(input logic [2:0] op, input logic [15:0] amt, input logic [15:0] np);
        valid     = 1'b1;
        operation = op;
        amount    = amt;
        new_pin   = np;
        step();
        valid = 1'b0;
        check("exec_state", 32'(current_state), 3);
        check("exec_nodone", 32'(done), 0);
        step();
        check("done_state", 32'(current_state), 4);
        check("done_pulse", 32'(done), 1);
    endtask

    task automatic logout();
        op_to_done(3'd4, 16'd0, 16'd0);
        step();
        check("exit_idle", 32'(current_state), 0);
        check("idle_bal", 32'(balance), 0);
    endtask

    initial begin
        // reset state
        step();
        step();
        check("rst_state", 32'(current_state), 0);
        check("rst_bal", 32'(balance), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(error_code), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_lang", 32'(lang_sel), 0);
        rst_n = 1'b1;

        // acc 2 inquiry
        language = 1'b1;
        login(2, 16'h1002);
        check("lang_latch", 32'(lang_sel), 1);
        check("inq_menu_bal", 32'(balance), 500);
        op_to_done(3'd0, 16'd0, 16'd0);
        check("inq_bal", 32'(balance), 500);
        check("inq_err", 32'(error_code), 0);
        step();
        check("inq_back_menu", 32'(current_state), 2);
        check("inq_done_low", 32'(done), 0);
        logout();

        // acc 5 withdraw 200 then 400
        login(5, 16'h1005);
        op_to_done(3'd1, 16'd200, 16'd0);
        check("wdr200_bal", 32'(balance), 300);
        check("wdr200_err", 32'(error_code), 0);
        step();
        op_to_done(3'd1, 16'd400, 16'd0);
        check("wdr400_err", 32'(error_code), 4);
        check("wdr400_bal", 32'(balance), 300);
        step();
        logout();

        // acc 1 deposit overflow then exact fill
        login(1, 16'h1001);
        op_to_done(3'd2, 16'd65100, 16'd0);
        check("dep_ovf_err", 32'(error_code), 5);
        check("dep_ovf_bal", 32'(balance), 500);
        step();
        op_to_done(3'd2, 16'd65035, 16'd0);
        check("dep_max_err", 32'(error_code), 0);
        check("dep_max_bal", 32'(balance), 65535);
        step();
        logout();

        // acc 3 lockout after three wrong PINs
        valid   = 1'b1;
        acc_num = AW'(3);
        step();
        check("lk_auth", 32'(current_state), 1);
        pin = 16'h0000;
        step();
        check("lk_try1_err", 32'(error_code), 2);
        check("lk_try1_state", 32'(current_state), 1);
        check("lk_try1_locked", 32'(locked), 0);
        step();
        check("lk_try2_err", 32'(error_code), 2);
        check("lk_try2_state", 32'(current_state), 1);
        step();
        check("lk_try3_err", 32'(error_code), 3);
        check("lk_try3_state", 32'(current_state), 0);
        check("lk_try3_locked", 32'(locked), 1);
        step();
        valid = 1'b0;
        check("lk_retry_err", 32'(error_code), 3);
        check("lk_retry_state", 32'(current_state), 0);
        check("lk_retry_locked", 32'(locked), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("lk_rst_locked", 32'(locked), 0);
        login(3, 16'h1003);
        logout();

        // acc 0 PIN change
        login(0, 16'h1000);
        op_to_done(3'd3, 16'd0, 16'hBEEF);
        step();
        logout();
        valid   = 1'b1;
        acc_num = AW'(0);
        step();
        pin = 16'h1000;
        step();
        check("oldpin_err", 32'(error_code), 2);
        check("oldpin_state", 32'(current_state), 1);
        pin = 16'hBEEF;
        step();
        valid = 1'b0;
        check("newpin_state", 32'(current_state), 2);
        check("newpin_err", 32'(error_code), 0);
        logout();

        // out-of-range account
        valid   = 1'b1;
        acc_num = AW'(16);
        step();
        valid = 1'b0;
        check("badacc_err", 32'(error_code), 1);
        check("badacc_state", 32'(current_state), 0);

        // illegal op, valid wins in expiry cycle, then timeout
        login(4, 16'h1004);
        valid     = 1'b1;
        operation = 3'd5;
        step();
        valid = 1'b0;
        check("illop_err", 32'(error_code), 7);
        check("illop_state", 32'(current_state), 2);
        repeat (1023) step();
        check("pre_expiry_state", 32'(current_state), 2);
        op_to_done(3'd0, 16'd0, 16'd0);
        check("expiry_valid_err", 32'(error_code), 0);
        step();
        repeat (1023) step();
        check("pre_timeout_state", 32'(current_state), 2);
        step();
        check("timeout_state", 32'(current_state), 0);
        check("timeout_err", 32'(error_code), 6);
        check("timeout_bal", 32'(balance), 0);

        // reset during EXEC
        login(6, 16'h1006);
        valid     = 1'b1;
        operation = 3'd1;
        amount    = 16'd100;
        step();
        valid = 1'b0;
        check("midrst_exec", 32'(current_state), 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_idle", 32'(current_state), 0);
        check("midrst_err", 32'(error_code), 0);
        login(6, 16'h1006);
        check("midrst_bal", 32'(balance), 500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
